// File: rtl/tree_adder_pkg.sv
// Shared definitions for the pipelined adder tree: the sideband tag carried with
// each beat, the level-count calculation and the per-level sum width.
package tree_adder_pkg;

    typedef struct packed {
        logic acc_en;
        logic last;
    } beat_tag_t;

    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

    // Each level grows by one bit, so a pairwise sum can never overflow.
    function automatic int level_width(input int p, input int k);
        return p + k;
    endfunction

endpackage

// File: rtl/tree_adder_stage.sv
// One registered level of the adder tree: N elements of W bits become N/2 sign-extended
// sums of W+1 bits, with a valid bit and a ready that lets bubbles collapse.
module tree_adder_stage
    import tree_adder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*W-1:0]         in_data,
    input  beat_tag_t              in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(N/2)*(W+1)-1:0] out_data,
    output beat_tag_t              out_tag
);

    localparam int OW = level_width(W, 1);

    logic [(N/2)*OW-1:0] sum_next;
    logic [(N/2)*OW-1:0] data_reg;
    beat_tag_t           tag_reg;
    logic                valid_reg;
    logic                load;

    genvar gi;
    generate
        for (gi = 0; gi < N / 2; gi++) begin : g_pair
            logic [W-1:0] a;
            logic [W-1:0] b;
            assign a = in_data[(2*gi)*W +: W];
            assign b = in_data[(2*gi+1)*W +: W];
            assign sum_next[gi*OW +: OW] = {a[W-1], a} + {b[W-1], b};
        end
    endgenerate

    // The register can take a new beat when empty or when its current beat leaves now.
    assign load     = !valid_reg || out_ready;
    assign in_ready = load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            tag_reg   <= '0;
        end else if (load) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= sum_next;
                tag_reg  <= in_tag;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_tag   = tag_reg;

endmodule

// File: rtl/pipelined_tree_accumulator.sv
// Sums INPUTS_AMOUNT signed elements per beat through a registered adder tree, then
// accumulates beats into a result that is presented on a valid/ready output register.
module pipelined_tree_accumulator
    import tree_adder_pkg::*;
#(
    parameter int P             = 8,
    parameter int INPUTS_AMOUNT = 8,
    parameter int OUT_WIDTH     = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic signed [INPUTS_AMOUNT*P-1:0] inputs_i,
    input  logic                            acc_en_i,
    input  logic                            in_last_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic signed [OUT_WIDTH-1:0]     out_o
);

    localparam int LEVELS = tree_levels(INPUTS_AMOUNT);
    localparam int SUM_W  = level_width(P, LEVELS);

    logic      lvl_valid [0:LEVELS];
    logic      lvl_ready [0:LEVELS];
    beat_tag_t lvl_tag   [0:LEVELS];

    logic signed [SUM_W-1:0]     tree_sum;
    logic signed [OUT_WIDTH-1:0] sum_ext;
    logic signed [OUT_WIDTH-1:0] acc_reg;
    logic signed [OUT_WIDTH-1:0] acc_next;
    logic signed [OUT_WIDTH-1:0] out_reg;
    logic                        out_valid_reg;
    logic                        acc_ready;
    logic                        acc_fire;

    assign lvl_valid[0] = in_valid_i;
    assign lvl_tag[0]   = '{acc_en: acc_en_i, last: in_last_i};
    assign in_ready_o   = rst_ni && lvl_ready[0];

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            localparam int N = INPUTS_AMOUNT >> gi;
            localparam int W = level_width(P, gi);

            logic [N*W-1:0]         stage_in;
            logic [(N/2)*(W+1)-1:0] stage_out;

            if (gi == 0) begin : g_first
                assign stage_in = inputs_i;
            end else begin : g_rest
                assign stage_in = g_level[gi-1].stage_out;
            end

            tree_adder_stage #(
                .N(N),
                .W(W)
            ) u_stage (
                .clk      (clk_i),
                .rst_n    (rst_ni),
                .in_valid (lvl_valid[gi]),
                .in_ready (lvl_ready[gi]),
                .in_data  (stage_in),
                .in_tag   (lvl_tag[gi]),
                .out_valid(lvl_valid[gi+1]),
                .out_ready(lvl_ready[gi+1]),
                .out_data (stage_out),
                .out_tag  (lvl_tag[gi+1])
            );
        end
    endgenerate

    assign tree_sum = g_level[LEVELS-1].stage_out;
    assign sum_ext  = OUT_WIDTH'(tree_sum);

    // The accumulate stage only moves when the result register can accept or drain.
    assign acc_ready         = !out_valid_reg || out_ready_i;
    assign lvl_ready[LEVELS] = acc_ready;
    assign acc_fire          = lvl_valid[LEVELS] && acc_ready;
    assign acc_next          = (lvl_tag[LEVELS].acc_en ? acc_reg : '0) + sum_ext;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_reg       <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (out_ready_i) begin
                out_valid_reg <= 1'b0;
            end
            if (acc_fire) begin
                if (lvl_tag[LEVELS].last) begin
                    out_reg       <= acc_next;
                    out_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end
        end
    end

    assign out_o       = out_reg;
    assign out_valid_o = out_valid_reg;

endmodule
